au_divider: RTL and testbench

- Multi-cycle signed fixed-point divider in the arithmetic unit (AU), directly downstream of the microcode sequencer.
- Consumes a decoded WAIT-class instruction (sequencer ctl_c=01), the destination field ctl_a and two register-file operands.
- Computes a Q(W-FRAC).FRAC quotient for Kalman-gain terms such as P/(P+R).
- Returns a one-cycle done pulse that drives the sequencer's continue_i, plus a register-file write strobe.

---
 rtl/kf_au_pkg.sv | 23 ++
 rtl/au_divider.sv | 144 ++++++++++++++
 tb/tb_au_divider.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/kf_au_pkg.sv
// Shared definitions for the Kalman-filter arithmetic unit: FSM encoding,
// sequencer control codes and the default fixed-point format.
package kf_au_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  // Sequencer ctl_c codes; a divide is issued while ctl_c == WAIT.
  localparam logic [1:0] INC  = 2'b00;
  localparam logic [1:0] WAIT = 2'b01;
  localparam logic [1:0] HALT = 2'b10;

  localparam int unsigned DEF_W    = 16;
  localparam int unsigned DEF_FRAC = 8;

  typedef enum logic [1:0] {
    StIdle = IDLE,
    StCalc = CALC,
    StFin  = FIN
  } div_state_e;

endpackage

// File: rtl/au_divider.sv
// Multi-cycle signed Q(W-FRAC).FRAC restoring divider with saturation,
// divide-by-zero detection and a one-cycle done / register write strobe.
module au_divider #(
  parameter int unsigned W    = kf_au_pkg::DEF_W,
  parameter int unsigned FRAC = kf_au_pkg::DEF_FRAC
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         issue,
  input  logic [4:0]   dst_addr,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic         wr_en,
  output logic [4:0]   wr_addr,
  output logic [W-1:0] quotient,
  output logic         ovf,
  output logic         div0
);
  import kf_au_pkg::*;

  localparam int unsigned     ITER     = W + FRAC;
  localparam int unsigned     CW       = $clog2(ITER);
  localparam logic [CW-1:0]   LastIter = CW'(ITER - 1);
  localparam logic [W-1:0]    MaxPos   = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]    MaxNeg   = {1'b1, {(W-1){1'b0}}};
  localparam logic [ITER-1:0] PosLim   = ITER'(MaxPos);
  localparam logic [ITER-1:0] NegLim   = ITER'(MaxNeg);

  div_state_e      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [ITER-1:0] num_q, num_d;  // numerator shifts out MSB-first, quotient bits shift in
  logic [W:0]      rem_q, rem_d;
  logic [W:0]      den_q, den_d;
  logic            neg_q, neg_d;
  logic [4:0]      addr_q, addr_d;
  logic [W-1:0]    quot_q, quot_d;
  logic            ovf_q, ovf_d;
  logic            div0_q, div0_d;

  logic [W:0]      a_ext, b_ext, a_abs, b_abs;
  logic [W+1:0]    r_shift, r_sub;
  logic            fits;
  logic [ITER-1:0] q_next;

  always_comb begin
    a_ext   = {dividend[W-1], dividend};
    b_ext   = {divisor[W-1], divisor};
    a_abs   = dividend[W-1] ? (~a_ext + (W+1)'(1)) : a_ext;
    b_abs   = divisor[W-1]  ? (~b_ext + (W+1)'(1)) : b_ext;
    r_shift = {rem_q, num_q[ITER-1]};
    r_sub   = r_shift - {1'b0, den_q};
    fits    = (r_shift >= {1'b0, den_q});
    q_next  = {num_q[ITER-2:0], fits};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    rem_d   = rem_q;
    den_d   = den_q;
    neg_d   = neg_q;
    addr_d  = addr_q;
    quot_d  = quot_q;
    ovf_d   = ovf_q;
    div0_d  = div0_q;
    unique case (state_q)
      StIdle: begin
        if (issue) begin
          addr_d = dst_addr;
          den_d  = b_abs;
          neg_d  = dividend[W-1] ^ divisor[W-1];
          num_d  = ITER'({a_abs, {FRAC{1'b0}}});
          rem_d  = '0;
          cnt_d  = '0;
          ovf_d  = 1'b0;
          div0_d = 1'b0;
          if (b_abs == '0) begin
            div0_d  = 1'b1;
            quot_d  = dividend[W-1] ? MaxNeg : MaxPos;
            state_d = StFin;
          end else begin
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        num_d = q_next;
        rem_d = fits ? (W+1)'(r_sub) : (W+1)'(r_shift);
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LastIter) begin
          state_d = StFin;
          // Negative results may reach 2^(W-1) exactly without saturating.
          if (neg_q) begin
            ovf_d  = (q_next > NegLim);
            quot_d = (q_next > NegLim) ? MaxNeg : (~q_next[W-1:0] + W'(1));
          end else begin
            ovf_d  = (q_next > PosLim);
            quot_d = (q_next > PosLim) ? MaxPos : q_next[W-1:0];
          end
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      num_q   <= '0;
      rem_q   <= '0;
      den_q   <= '0;
      neg_q   <= 1'b0;
      addr_q  <= '0;
      quot_q  <= '0;
      ovf_q   <= 1'b0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      rem_q   <= rem_d;
      den_q   <= den_d;
      neg_q   <= neg_d;
      addr_q  <= addr_d;
      quot_q  <= quot_d;
      ovf_q   <= ovf_d;
      div0_q  <= div0_d;
    end
  end

  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StFin);
  assign wr_en    = done;
  assign wr_addr  = addr_q;
  assign quotient = quot_q;
  assign ovf      = ovf_q;
  assign div0     = div0_q;

endmodule

// File: tb/tb_au_divider.sv
// Randomised and directed bench for au_divider against an integer-arithmetic
// reference model, including a small sequencer model for back-to-back divides.
module tb_au_divider;
  import kf_au_pkg::*;

  localparam int W    = 16;
  localparam int FRAC = 8;
  localparam int ITER = W + FRAC;

  logic         clk = 1'b0;
  logic         rst;
  logic         issue, issue_drv, seq_mode;
  logic [4:0]   dst_addr;
  logic [W-1:0] dividend, divisor;
  logic         busy, done, wr_en, ovf, div0;
  logic [4:0]   wr_addr;
  logic [W-1:0] quotient;

  logic [1:0]   prog [4];
  logic [1:0]   pc;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign issue = seq_mode ? (prog[pc] == WAIT) : issue_drv;

  au_divider #(.W(W), .FRAC(FRAC)) dut (
    .clk      (clk),
    .rst      (rst),
    .issue    (issue),
    .dst_addr (dst_addr),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .quotient (quotient),
    .ovf      (ovf),
    .div0     (div0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: exact integer quotient, truncated toward zero, then saturated.
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic o, output logic z);
    longint sa, sb, mag;
    bit     neg;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    o  = 1'b0;
    z  = 1'b0;
    if (sb == 0) begin
      z = 1'b1;
      q = (sa >= 0) ? 16'h7FFF : 16'h8000;
      return;
    end
    mag = ((sa < 0 ? -sa : sa) * (longint'(1) << FRAC)) / (sb < 0 ? -sb : sb);
    neg = (sa < 0) != (sb < 0);
    if (neg) begin
      if (mag > 32768) begin q = 16'h8000; o = 1'b1; end
      else q = W'(-mag);
    end else begin
      if (mag > 32767) begin q = 16'h7FFF; o = 1'b1; end
      else q = W'(mag);
    end
  endfunction

  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [4:0] addr, input bit hold_issue);
    logic [W-1:0] eq;
    logic         eo, ez;
    int           lat, exp_lat;
    ref_div(a, b, eq, eo, ez);
    exp_lat  = (b == '0) ? 1 : ITER + 1;
    dividend = a;
    divisor  = b;
    dst_addr = addr;
    issue_drv = 1'b1;
    @(posedge clk); #1;
    if (!hold_issue) issue_drv = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
    dst_addr = 5'($urandom);
    check("busy_after_accept", busy, 1);
    lat = 1;
    while (!done && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    issue_drv = 1'b0;
    check("latency", lat, exp_lat);
    check("wr_en", wr_en, 1);
    check("wr_addr", wr_addr, addr);
    check("quotient", quotient, eq);
    check("ovf", ovf, eo);
    check("div0", div0, ez);
    @(posedge clk); #1;
    check("done_one_cycle", done, 0);
    check("idle_after_done", busy, 0);
    check("quotient_held", quotient, eq);
  endtask

  initial begin
    logic [W-1:0] sa [3];
    logic [W-1:0] sb [3];
    logic [W-1:0] sq [2];
    logic         so, sz, d;
    int           n_done, first, second, seen;

    rst = 1'b1; issue_drv = 1'b0; seq_mode = 1'b0; pc = '0;
    dividend = '0; divisor = '0; dst_addr = '0;
    prog[0] = WAIT; prog[1] = WAIT; prog[2] = HALT; prog[3] = INC;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_quotient", quotient, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_ovf", ovf, 0);
    check("rst_div0", div0, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases from the plan, issue held high on the first.
    run_div(16'h0300, 16'h0180, 5'd5, 1'b1);
    run_div(16'hFF00, 16'h0400, 5'd1, 1'b0);
    run_div(16'h0100, 16'h0300, 5'd2, 1'b0);
    run_div(16'h8000, 16'h0100, 5'd3, 1'b1);
    run_div(16'h7F00, 16'h0001, 5'd4, 1'b0);
    run_div(16'h0100, 16'h0000, 5'd6, 1'b0);
    run_div(16'hFF00, 16'h0000, 5'd7, 1'b1);
    run_div(16'h8100, 16'h0001, 5'd8, 1'b0);

    // Reset in the middle of CALC, right after a saturating result.
    dividend = 16'h0300; divisor = 16'h0180; dst_addr = 5'd9; issue_drv = 1'b1;
    @(posedge clk); #1;
    issue_drv = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_wr_en", wr_en, 0);
    check("midrst_quotient", quotient, 0);
    check("midrst_wr_addr", wr_addr, 0);
    check("midrst_ovf", ovf, 0);
    check("midrst_div0", div0, 0);
    seen = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    check("midrst_no_done", seen, 0);
    run_div(16'h0280, 16'hFF80, 5'd10, 1'b0);

    // Randomised divides with weighted divisor selection.
    for (int i = 0; i < 30; i++) begin
      logic [W-1:0] a, b;
      int           m;
      a = W'($urandom);
      m = $urandom_range(0, 7);
      if (m == 0)      b = '0;
      else if (m == 1) b = W'($urandom_range(1, 3));
      else if (m == 2) b = -W'($urandom_range(1, 3));
      else             b = W'($urandom);
      run_div(a, b, 5'($urandom), bit'($urandom_range(0, 1)));
    end

    // Two WAIT instructions driven by a sequencer model: PC advances on done.
    sa[0] = 16'h0500; sb[0] = 16'h0200;
    sa[1] = 16'hFD00; sb[1] = 16'h0700;
    sa[2] = 16'h0000; sb[2] = 16'h0001;
    ref_div(sa[0], sb[0], sq[0], so, sz);
    ref_div(sa[1], sb[1], sq[1], so, sz);
    pc = '0;
    dividend = sa[0]; divisor = sb[0]; dst_addr = 5'd11;
    seq_mode = 1'b1;
    n_done = 0; first = -1; second = -1;
    for (int c = 1; c <= 80; c++) begin
      d = done;
      @(posedge clk); #1;
      if (d) begin
        pc = pc + 2'd1;
        dividend = sa[pc];
        divisor  = sb[pc];
      end
      if (done) begin
        if (n_done < 2) check("seq_quotient", quotient, sq[n_done]);
        n_done++;
        if (first < 0) first = c;
        else if (second < 0) second = c;
      end
    end
    seq_mode = 1'b0;
    check("seq_done_count", n_done, 2);
    check("seq_pc", pc, 2);
    check("seq_first_latency", first, ITER + 1);
    check("seq_b2b_gap", second - first, ITER + 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
